mvu_apb_cfg_master: RTL and testbench
=====================================

// Module: mvu_apb_cfg_master
// PURPOSE
//  APB initiator that turns a queue of CSR requests into APB transfers aimed at the MVU CSR slave.
//  Decouples host/controller timing from APB phase sequencing.
//  Sits between the control processor (or test sequencer) and the mvutop APB slave port.
//  Address map: paddr[APB_ADDR_WIDTH-1:12] selects the MVU; paddr[11:0] is the mvu_csr_t offset.
// PARAMETERS
//  APB_ADDR_WIDTH  15  APB address width (12-bit CSR offset + MVU id bits)
//  APB_DATA_WIDTH  32  APB data width
//  FIFO_DEPTH      4   request queue depth; power of 2, >=2
//  TIMEOUT_CYCLES  256 ACCESS-phase wait limit; used only with MVU_APB_TIMEOUT_EN
// PORTS
//  clk        in   1               single clock
//  rst        in   1               asynchronous, active-high reset
//  req_valid  in   1               request offered
//  req_ready  out  1               request queue can accept
//  req_write  in   1               1=write, 0=read
//  req_addr   in   APB_ADDR_WIDTH  target address {mvu_id, csr}
//  req_wdata  in   APB_DATA_WIDTH  write data
//  rsp_valid  out  1               one-cycle completion pulse
//  rsp_rdata  out  APB_DATA_WIDTH  read data (0 for writes)
//  rsp_err    out  1               pslverr sampled, or timeout
//  busy       out  1               queue non-empty or transfer in flight
//  paddr      out  APB_ADDR_WIDTH  APB address
//  psel       out  1               APB select
//  penable    out  1               APB enable
//  pwrite     out  1               APB direction
//  pwdata     out  APB_DATA_WIDTH  APB write data
//  prdata     in   APB_DATA_WIDTH  APB read data
//  pready     in   1               APB ready
//  pslverr    in   1               APB error
// BEHAVIOUR
//  Reset: all outputs 0, except req_ready=1. Queue is emptied and the FSM goes to IDLE.
//  Reset mid-transfer: psel and penable drop immediately (async). The in-flight request is lost.
//  Request handshake: a request is accepted when req_valid & req_ready.
//    req_ready = !full. A push while full is ignored (no bypass).
//  FSM states: IDLE, SETUP, ACCESS.
//    IDLE: if queue non-empty, pop the head into the paddr/pwrite/pwdata registers; go to SETUP next cycle.
//    SETUP: psel=1, penable=0. Always go to ACCESS.
//    ACCESS: psel=1, penable=1. Hold until pready=1.
//      On pready: capture prdata (reads) and pslverr.
//      If queue non-empty: pop the next request and go straight to SETUP (back-to-back, no IDLE gap).
//      Otherwise go to IDLE with psel=0.
//  Signal stability: paddr, pwrite and pwdata stay stable from SETUP through the last ACCESS cycle.
//    pwdata value is don't-care for reads; it is held at its last value.
//  Responses: rsp_valid pulses exactly one cycle, on the cycle after pready is sampled in ACCESS.
//    rsp_rdata = prdata for reads, 0 for writes. rsp_err = pslverr.
//    There is no rsp backpressure. Responses come out in request order.
//  Minimum transfer time: 2 APB cycles. Throughput with a full queue: 1 transfer per 2 cycles when the slave has zero wait states.
//  Latency: req accepted at cycle t into an empty, idle block -> SETUP at t+2, ACCESS at t+3, rsp_valid at t+4 (pready=1).
//  busy = (state!=IDLE) | !empty.
//  Simultaneous push and pop in the same cycle are both honoured; occupancy is unchanged.
// CONFIGURATION
//  Macro MVU_APB_TIMEOUT_EN:
//    Defined: a counter runs in ACCESS. If TIMEOUT_CYCLES cycles pass without pready:
//      drop psel/penable, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, then continue with the next request.
//    Undefined: ACCESS waits indefinitely; no counter logic is built.
// STRUCTURE
//  apb_pkg holds:
//    - apb_req_t struct {write, addr, wdata}
//    - apb_mst_state_e enum {IDLE, SETUP, ACCESS}
//  mvu_pkg supplies APB_ADDR_WIDTH and the mvu_csr_t offsets used by benches.
//  One sub-module: mvu_apb_req_fifo, a synchronous FIFO of apb_req_t with full/empty and async active-high reset.
// TESTING
//  1. Single write to addr {mvu 1, CSR_MVUQUANT}, data 0x5, slave pready=1
//     -> psel 1 for 2 cycles, penable only in the 2nd; rsp_valid at t+4, rsp_err=0, rsp_rdata=0.
//  2. Single read, slave inserts 3 wait states, prdata=0xDEADBEEF
//     -> paddr held for 5 cycles; rsp_rdata=0xDEADBEEF.
//  3. Push 5 writes back-to-back with FIFO_DEPTH=4, zero-wait slave
//     -> req_ready drops once full; transfers are SETUP/ACCESS pairs with no IDLE gap; 5 responses in order.
//  4. Slave asserts pslverr with pready on the 2nd of 3 requests
//     -> only the 2nd response has rsp_err=1; the 3rd still completes.
//  5. rst asserted during ACCESS
//     -> psel/penable go to 0 in the same cycle; busy=0 and req_ready=1 after release.
//  6. With MVU_APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0
//     -> rsp_valid with rsp_err=1 after 8 ACCESS cycles; the next queued request starts.

Source files
------------

// File: rtl/mvu_apb_cfg_master_pkg.sv
// Shared types for the MVU APB configuration master: bus widths, CSR offsets,
// queued request record and the initiator FSM state encoding.
package mvu_apb_cfg_master_pkg;

    localparam int APB_ADDR_WIDTH = 15;
    localparam int APB_DATA_WIDTH = 32;
    localparam int MVU_CSR_WIDTH  = 12;
    localparam int MVU_ID_WIDTH   = APB_ADDR_WIDTH - MVU_CSR_WIDTH;

    typedef enum logic [MVU_CSR_WIDTH-1:0] {
        CSR_MVUSTART    = 12'h000,
        CSR_MVUWBASEPTR = 12'h004,
        CSR_MVUQUANT    = 12'h020,
        CSR_MVUCOMMAND  = 12'h040
    } mvu_csr_t;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    function automatic logic [APB_ADDR_WIDTH-1:0] mvu_csr_addr(
        input logic [MVU_ID_WIDTH-1:0] mvu_id,
        input mvu_csr_t                csr
    );
        return {mvu_id, csr};
    endfunction

endpackage

// File: rtl/mvu_apb_cfg_master_if.sv
// APB bus between the configuration master and the MVU CSR slave.
interface mvu_apb_cfg_master_if;
    import mvu_apb_cfg_master_pkg::*;

    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/mvu_apb_req_fifo.sv
// Synchronous request queue of apb_req_t; pushes while full and pops while
// empty are ignored. DEPTH must be a power of two.
module mvu_apb_req_fifo
    import mvu_apb_cfg_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  apb_req_t push_data,
    input  logic     pop,
    output apb_req_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    apb_req_t      mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mvu_apb_cfg_master.sv
// APB initiator draining a queue of CSR requests into the MVU CSR slave.
// Optional ACCESS-phase timeout enabled by defining MVU_APB_TIMEOUT_EN.
module mvu_apb_cfg_master
    import mvu_apb_cfg_master_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    mvu_apb_cfg_master_if.master      apb
);

    // state  | meaning
    // IDLE   | bus idle, waiting for a queued request
    // SETUP  | psel=1, penable=0, address phase
    // ACCESS | psel=1, penable=1, waiting for pready (or timeout)

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("mvu_apb_cfg_master: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    apb_mst_state_e            state_q, state_d;
    apb_req_t                  head;
    logic                      fifo_full, fifo_empty, pop;
    logic                      xfer_done;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      rsp_valid_d, rsp_err_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_d;

    mvu_apb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data ('{write: req_write, addr: req_addr, wdata: req_wdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef MVU_APB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q;

    // Loaded in SETUP so terminal count is reached on the TIMEOUT_CYCLES-th ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= TMO_LOAD;
        end else if (state_q == ACCESS && tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        xfer_done   = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    xfer_done   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = apb.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
                end
`ifdef MVU_APB_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    xfer_done   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
`endif
                if (xfer_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            // Address-phase registers only change on a pop, so they hold through ACCESS.
            if (pop) begin
                paddr_q  <= head.addr;
                pwrite_q <= head.write;
                pwdata_q <= head.wdata;
            end
        end
    end

    assign apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign apb.penable = (state_q == ACCESS);
    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;

    assign req_ready = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mvu_apb_cfg_master.sv
// Directed bench for mvu_apb_cfg_master: table of single transfers plus
// hand-written burst, error, reset and (optional) timeout sequences.
module tb_mvu_apb_cfg_master;
    import mvu_apb_cfg_master_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic                      req_write = 1'b0;
    logic [APB_ADDR_WIDTH-1:0] req_addr = '0;
    logic [APB_DATA_WIDTH-1:0] req_wdata = '0;
    logic                      rsp_valid;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;

    mvu_apb_cfg_master_if apb_if ();

    mvu_apb_cfg_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .apb       (apb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
        int                        waits;
        logic [APB_DATA_WIDTH-1:0] prdata;
        logic                      slverr;
        logic [APB_DATA_WIDTH-1:0] exp_rdata;
        logic                      exp_err;
    } vec_t;

    vec_t                      vecs [5];
    logic [APB_ADDR_WIDTH-1:0] b_addr [8];
    logic [APB_DATA_WIDTH-1:0] b_data [8];

    function automatic vec_t mk(input logic w, input logic [APB_ADDR_WIDTH-1:0] a,
                                input logic [31:0] wd, input int ws, input logic [31:0] rd,
                                input logic se, input logic [31:0] er, input logic ee);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.waits = ws;
        v.prdata = rd; v.slverr = se; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One request into an idle block; slave inserts v.waits wait states.
    task automatic do_single(input int idx, input vec_t v);
        int  waits = 0;
        int  sel_cycles = 0;
        int  en_cycles = 0;
        bit  got = 0;
        string tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc < 40 && !got; cyc++) begin
            if (rsp_valid) begin
                got = 1;
                check({tag, " latency"}, cyc, 4 + v.waits);
                check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
                check({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
            end
            if (apb_if.psel) begin
                sel_cycles++;
                check({tag, " paddr held"}, {17'd0, apb_if.paddr}, {17'd0, v.addr});
                check({tag, " pwrite"}, {31'd0, apb_if.pwrite}, {31'd0, v.write});
                if (v.write) check({tag, " pwdata"}, apb_if.pwdata, v.wdata);
            end
            if (apb_if.penable) en_cycles++;
            if (apb_if.penable && waits == v.waits) begin
                apb_if.pready = 1'b1; apb_if.prdata = v.prdata; apb_if.pslverr = v.slverr;
            end else begin
                apb_if.pready = 1'b0; apb_if.prdata = '0; apb_if.pslverr = 1'b0;
                if (apb_if.penable) waits++;
            end
            @(negedge clk);
        end
        apb_if.pready = 1'b0; apb_if.prdata = '0; apb_if.pslverr = 1'b0;
        check({tag, " rsp seen"}, {31'd0, got}, 32'd1);
        check({tag, " psel cycles"}, sel_cycles, 2 + v.waits);
        check({tag, " penable cycles"}, en_cycles, 1 + v.waits);
    endtask

    // n writes offered back to back; with stall the slave holds pready low until the queue fills.
    task automatic burst(input string tag, input int n, input bit stall, input logic [7:0] err_mask);
        int pushed = 0, done = 0, rsp_cnt = 0, gap_err = 0;
        bit saw_full = 0, started = 0;
        apb_if.pready = stall ? 1'b0 : 1'b1;
        @(negedge clk);
        for (int c = 0; c < 200 && rsp_cnt < n; c++) begin
            if (rsp_valid) begin
                check($sformatf("%s rsp%0d err", tag, rsp_cnt), {31'd0, rsp_err}, {31'd0, err_mask[rsp_cnt]});
                check($sformatf("%s rsp%0d rdata", tag, rsp_cnt), rsp_rdata, 32'd0);
                rsp_cnt++;
            end
            if (!req_ready) saw_full = 1;
            if (saw_full) apb_if.pready = 1'b1;
            if (apb_if.psel) started = 1;
            if (started && done < n && !apb_if.psel) gap_err++;
            if (apb_if.psel && apb_if.penable && apb_if.pready) begin
                check($sformatf("%s xfer%0d paddr", tag, done), {17'd0, apb_if.paddr}, {17'd0, b_addr[done]});
                check($sformatf("%s xfer%0d pwdata", tag, done), apb_if.pwdata, b_data[done]);
                apb_if.pslverr = err_mask[done];
                done++;
            end else begin
                apb_if.pslverr = 1'b0;
            end
            if (pushed < n) begin
                req_valid = 1'b1; req_write = 1'b1;
                req_addr = b_addr[pushed]; req_wdata = b_data[pushed];
                if (req_ready) pushed++;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0; apb_if.pready = 1'b0; apb_if.pslverr = 1'b0;
        check({tag, " pushed"}, pushed, n);
        check({tag, " transfers"}, done, n);
        check({tag, " responses"}, rsp_cnt, n);
        check({tag, " idle gaps"}, gap_err, 0);
        if (stall) check({tag, " req_ready dropped"}, {31'd0, saw_full}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apb_if.pready = 1'b0; apb_if.prdata = '0; apb_if.pslverr = 1'b0;

        vecs[0] = mk(1'b1, mvu_csr_addr(3'd1, CSR_MVUQUANT),    32'h5,        0, 32'h0,        1'b0, 32'h0,        1'b0);
        vecs[1] = mk(1'b0, mvu_csr_addr(3'd2, CSR_MVUWBASEPTR), 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
        vecs[2] = mk(1'b1, mvu_csr_addr(3'd3, CSR_MVUCOMMAND),  32'hA5A5_0F0F, 1, 32'h1234,    1'b1, 32'h0,        1'b1);
        vecs[3] = mk(1'b0, mvu_csr_addr(3'd0, CSR_MVUSTART),    32'h0,        2, 32'hCAFE0001, 1'b1, 32'hCAFE0001, 1'b1);
        vecs[4] = mk(1'b0, mvu_csr_addr(3'd7, CSR_MVUCOMMAND),  32'h0,        0, 32'h12345678, 1'b0, 32'h12345678, 1'b0);
        for (int i = 0; i < 8; i++) begin
            b_addr[i] = mvu_csr_addr(3'(i), CSR_MVUQUANT);
            b_data[i] = 32'h1000_0000 + 32'(i);
        end

        #12;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset psel/penable", {30'd0, apb_if.psel, apb_if.penable}, 32'd0);
        check("reset paddr", {17'd0, apb_if.paddr}, 32'd0);
        check("reset pwdata", apb_if.pwdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) do_single(i, vecs[i]);

        burst("fill", 5, 1'b1, 8'b0000_0000);
        repeat (2) @(negedge clk);
        burst("slverr", 3, 1'b0, 8'b0000_0010);
        repeat (2) @(negedge clk);

`ifdef MVU_APB_TIMEOUT_EN
        begin
            int en_a = 0, rsp_n = 0;
            logic [APB_ADDR_WIDTH-1:0] a_addr = mvu_csr_addr(3'd4, CSR_MVUQUANT);
            logic [APB_ADDR_WIDTH-1:0] b2_addr = mvu_csr_addr(3'd5, CSR_MVUQUANT);
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b1; req_addr = a_addr; req_wdata = 32'h11;
            @(negedge clk);
            req_addr = b2_addr; req_wdata = 32'h22;
            @(negedge clk);
            req_valid = 1'b0;
            for (int c = 0; c < 60 && rsp_n < 2; c++) begin
                if (rsp_valid) begin
                    if (rsp_n == 0) begin
                        check("timeout access cycles", en_a, 8);
                        check("timeout rsp_err", {31'd0, rsp_err}, 32'd1);
                        check("timeout rsp_rdata", rsp_rdata, 32'd0);
                    end else begin
                        check("after timeout rsp_err", {31'd0, rsp_err}, 32'd0);
                    end
                    rsp_n++;
                end
                if (apb_if.penable && apb_if.paddr == a_addr) en_a++;
                apb_if.pready = apb_if.penable && apb_if.paddr == b2_addr;
                @(negedge clk);
            end
            apb_if.pready = 1'b0;
            check("timeout responses", rsp_n, 2);
        end
`endif

        begin
            bit saw_access = 0, stray = 0;
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; req_addr = mvu_csr_addr(3'd6, CSR_MVUSTART);
            @(negedge clk);
            req_valid = 1'b0;
            for (int c = 0; c < 10 && !saw_access; c++) begin
                if (apb_if.penable) saw_access = 1;
                else @(negedge clk);
            end
            check("rst: reached ACCESS", {31'd0, saw_access}, 32'd1);
            #2 rst = 1'b1;
            #1;
            check("rst: psel/penable drop", {30'd0, apb_if.psel, apb_if.penable}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (apb_if.psel || rsp_valid) stray = 1;
            end
            check("rst: busy after release", {31'd0, busy}, 32'd0);
            check("rst: req_ready after release", {31'd0, req_ready}, 32'd1);
            check("rst: request lost", {31'd0, stray}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
